// File: rtl/approx_eval_sequencer.sv
// approx_eval_sequencer
//
// Exhaustive error-evaluation controller for an exact/approximate pair of
// combinational circuits. The block sweeps every input vector
// 0..2^N_IN-1, registers |exact - approx| for each one, and accumulates the
// worst-case error, the error sum and the mismatch count. It then reports
// pass/fail against the threshold ET.
//
// Ports
//   clk, rst        system clock (rising edge), async active-high reset
//   start           level-sampled sweep launch, honoured only in IDLE
//   abort           ends a sweep in progress; results are marked invalid
//   vec             input vector driven to both circuits
//   exact_out       combinational output of the exact circuit for vec
//   approx_out      combinational output of the approximate circuit for vec
//   busy            high in SWEEP and DRAIN
//   done            one-cycle pulse when the results are final
//   valid, pass     result qualifiers (pass is meaningful only with valid)
//   max_err, err_sum, err_count, first_fail_vec   accumulated results
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; results from the last sweep are held
// SWEEP  | drive vec, capture |exact - approx| into d_q, accumulate d_q
// DRAIN  | vec frozen; accumulate the last captured error, then finish
// DONE   | one-cycle done pulse with valid/pass settled, then back to IDLE

module approx_eval_sequencer #(
    parameter int N_IN         = 4,
    parameter int N_OUT        = 3,
    parameter int ET           = 5,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [N_IN-1:0]       vec,
    input  logic [N_OUT-1:0]      exact_out,
    input  logic [N_OUT-1:0]      approx_out,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic                  pass,
    output logic [N_OUT-1:0]      max_err,
    output logic [N_OUT+N_IN-1:0] err_sum,
    output logic [N_IN:0]         err_count,
    output logic [N_IN-1:0]       first_fail_vec
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    logic [1:0]            state_q, state_d;
    logic [N_IN-1:0]       vec_q, vec_d;
    logic [N_OUT-1:0]      d_q, d_d;
    logic [N_IN-1:0]       tag_q, tag_d;
    logic                  d_vld_q, d_vld_d;
    logic [N_OUT-1:0]      max_err_q, max_err_d;
    logic [N_OUT+N_IN-1:0] err_sum_q, err_sum_d;
    logic [N_IN:0]         err_count_q, err_count_d;
    logic [N_IN-1:0]       ffv_q, ffv_d;
    logic                  fail_q, fail_d;
    logic                  valid_q, valid_d;
    logic                  pass_q, pass_d;

    // Subtract one bit wider so the sign survives, then fold to a magnitude
    // that always fits back into N_OUT bits.
    logic [N_OUT:0]   diff_w;
    logic [N_OUT:0]   neg_w;
    logic [N_OUT-1:0] abs_w;

    always_comb begin
        diff_w = {1'b0, exact_out} - {1'b0, approx_out};
        neg_w  = {(N_OUT+1){1'b0}} - diff_w;
        abs_w  = diff_w[N_OUT] ? neg_w[N_OUT-1:0] : diff_w[N_OUT-1:0];
    end

    logic d_gt_et;
    logic stop_hit;
    logic acc_en;
    logic abort_take;

    assign d_gt_et  = (int'(d_q) > ET);
    // Early stop fires on the first over-threshold error reaching the
    // accumulate stage; the vector captured on the same edge still drains.
    assign stop_hit = (STOP_ON_FAIL != 0) && d_vld_q && d_gt_et && !fail_q;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        d_d         = d_q;
        tag_d       = tag_q;
        d_vld_d     = d_vld_q;
        max_err_d   = max_err_q;
        err_sum_d   = err_sum_q;
        err_count_d = err_count_q;
        ffv_d       = ffv_q;
        fail_d      = fail_q;
        valid_d     = valid_q;
        pass_d      = pass_q;
        acc_en      = 1'b0;
        abort_take  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_SWEEP;
                    vec_d       = '0;
                    d_d         = '0;
                    tag_d       = '0;
                    d_vld_d     = 1'b0;
                    max_err_d   = '0;
                    err_sum_d   = '0;
                    err_count_d = '0;
                    ffv_d       = '0;
                    fail_d      = 1'b0;
                    valid_d     = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    abort_take = 1'b1;
                end else begin
                    acc_en  = d_vld_q;
                    d_d     = abs_w;
                    tag_d   = vec_q;
                    d_vld_d = 1'b1;
                    // vec holds on the last vector or on an early stop.
                    if (vec_q == VEC_LAST || stop_hit) begin
                        state_d = S_DRAIN;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    abort_take = 1'b1;
                end else if (d_vld_q) begin
                    acc_en  = 1'b1;
                    d_vld_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    pass_d  = !fail_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (acc_en) begin
            if (d_q > max_err_q) begin
                max_err_d = d_q;
            end
            err_sum_d   = err_sum_q + (N_OUT+N_IN)'(d_q);
            err_count_d = err_count_q + (N_IN+1)'(d_q != '0);
            if (d_gt_et && !fail_q) begin
                ffv_d  = tag_q;
                fail_d = 1'b1;
            end
        end

        // Abort wins over completion and early stop; partial sums are kept.
        if (abort_take) begin
            state_d = S_DONE;
            d_vld_d = 1'b0;
            valid_d = 1'b0;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            d_q         <= '0;
            tag_q       <= '0;
            d_vld_q     <= 1'b0;
            max_err_q   <= '0;
            err_sum_q   <= '0;
            err_count_q <= '0;
            ffv_q       <= '0;
            fail_q      <= 1'b0;
            valid_q     <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            d_q         <= d_d;
            tag_q       <= tag_d;
            d_vld_q     <= d_vld_d;
            max_err_q   <= max_err_d;
            err_sum_q   <= err_sum_d;
            err_count_q <= err_count_d;
            ffv_q       <= ffv_d;
            fail_q      <= fail_d;
            valid_q     <= valid_d;
            pass_q      <= pass_d;
        end
    end

    assign vec            = vec_q;
    assign busy           = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign valid          = valid_q;
    assign pass           = pass_q;
    assign max_err        = max_err_q;
    assign err_sum        = err_sum_q;
    assign err_count      = err_count_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_approx_eval_sequencer.sv
// Directed bench for approx_eval_sequencer. Two instances share clock and
// reset: dut uses the default configuration, dut_sof has STOP_ON_FAIL = 1.
// The circuit pair is modelled by functions selected with mode.

module tb_approx_eval_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, start_sof, abort_sof;

    logic [3:0] vec, vec_sof;
    logic [2:0] exact_out, approx_out, exact_sof, approx_sof;
    logic       busy, done, valid, pass;
    logic       busy_sof, done_sof, valid_sof, pass_sof;
    logic [2:0] max_err, max_err_sof;
    logic [6:0] err_sum, err_sum_sof;
    logic [4:0] err_count, err_count_sof;
    logic [3:0] ffv, ffv_sof;

    int mode = 0;
    int tests = 0;
    int failed = 0;
    int done_cnt = 0;
    int vec_sof_max = 0;
    int cyc;
    int dc0;

    always #5 clk = ~clk;

    // mode 0: both circuits are |in[1:0] - in[3:2]|
    // mode 1: exact = 0; approx = 7 at vec 9, 6 at vec 12, else 0
    // mode 2: exact = in[3:2]; approx = exact + 5 at vec 3 only
    function automatic logic [2:0] f_exact(input int m, input logic [3:0] v);
        logic [2:0] a, b;
        a = {1'b0, v[1:0]};
        b = {1'b0, v[3:2]};
        case (m)
            0:       return (a >= b) ? a - b : b - a;
            2:       return b;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] f_approx(input int m, input logic [3:0] v);
        case (m)
            1: begin
                if (v == 4'd9)  return 3'd7;
                if (v == 4'd12) return 3'd6;
                return 3'd0;
            end
            2: return (v == 4'd3) ? f_exact(m, v) + 3'd5 : f_exact(m, v);
            default: return f_exact(m, v);
        endcase
    endfunction

    always_comb begin
        exact_out  = f_exact(mode, vec);
        approx_out = f_approx(mode, vec);
        exact_sof  = f_exact(mode, vec_sof);
        approx_sof = f_approx(mode, vec_sof);
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (int'(vec_sof) > vec_sof_max) vec_sof_max <= int'(vec_sof);
    end

    approx_eval_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec(vec), .exact_out(exact_out), .approx_out(approx_out),
        .busy(busy), .done(done), .valid(valid), .pass(pass),
        .max_err(max_err), .err_sum(err_sum), .err_count(err_count),
        .first_fail_vec(ffv)
    );

    approx_eval_sequencer #(.STOP_ON_FAIL(1)) dut_sof (
        .clk(clk), .rst(rst), .start(start_sof), .abort(abort_sof),
        .vec(vec_sof), .exact_out(exact_sof), .approx_out(approx_sof),
        .busy(busy_sof), .done(done_sof), .valid(valid_sof), .pass(pass_sof),
        .max_err(max_err_sof), .err_sum(err_sum_sof), .err_count(err_count_sof),
        .first_fail_vec(ffv_sof)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns the edge number (start edge = 0) after which done was first
    // seen high, or 0 if done never came within the budget.
    task automatic wait_done(input bit sel, output int c);
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if ((sel ? done_sof : done) === 1'b1) begin
                c = i;
                break;
            end
        end
    endtask

    task automatic start_sweep();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_vec0", vec, 0);
    endtask

    task automatic check_results(input string tag, input int mx, input int sm, input int cnt,
                                 input int fv, input int vl, input int ps);
        check({tag, "_max"},   max_err, mx);
        check({tag, "_sum"},   err_sum, sm);
        check({tag, "_cnt"},   err_count, cnt);
        check({tag, "_ffv"},   ffv, fv);
        check({tag, "_valid"}, valid, vl);
        check({tag, "_pass"},  pass, ps);
        check({tag, "_busy"},  busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start_sof = 1'b0; abort_sof = 1'b0;
        step();
        check("rst_vec", vec, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_results("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();

        // 1: identical circuits
        mode = 0;
        start_sweep();
        wait_done(0, cyc);
        check("t1_latency", cyc, 18);
        check_results("t1", 0, 0, 0, 0, 1, 1);
        step();
        check("t1_done_pulse", done, 0);

        // 2: two injected errors, 7 at vec 9 and 6 at vec 12
        mode = 1;
        start_sweep();
        wait_done(0, cyc);
        check("t2_latency", cyc, 18);
        check_results("t2", 7, 13, 2, 9, 1, 0);
        step();

        // 3: same stimulus, early stop instance
        start_sof = 1'b1;
        step();
        start_sof = 1'b0;
        wait_done(1, cyc);
        check("t3_early", (cyc > 0 && cyc < 18), 1);
        check("t3_max", max_err_sof, 7);
        check("t3_sum", err_sum_sof, 7);
        check("t3_cnt", err_count_sof, 1);
        check("t3_ffv", ffv_sof, 9);
        check("t3_valid", valid_sof, 1);
        check("t3_pass", pass_sof, 0);
        check("t3_busy", busy_sof, 0);
        check("t3_vec_bound", (vec_sof_max <= 10), 1);
        step();

        // 4: error exactly at threshold; previous results held until start
        mode = 2;
        check("t4_hold_valid", valid, 1);
        check("t4_hold_max", max_err, 7);
        start_sweep();
        check("t4_cleared_max", max_err, 0);
        wait_done(0, cyc);
        check("t4_latency", cyc, 18);
        check_results("t4", 5, 5, 1, 0, 1, 1);
        step();

        // 5: abort sampled on edge 6, then start+abort together, then a clean sweep
        mode = 0;
        start_sweep();
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_done", done, 1);
        check("t5_abort_valid", valid, 0);
        check("t5_abort_pass", pass, 0);
        check("t5_abort_busy", busy, 0);
        step();
        check("t5_after_done", done, 0);
        check("t5_after_busy", busy, 0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("t5_start_abort_busy", busy, 0);
        mode = 1;
        start_sweep();
        wait_done(0, cyc);
        check("t5_latency", cyc, 18);
        check_results("t5", 7, 13, 2, 9, 1, 0);
        step();

        // 6: reset mid-sweep, then start held high through a whole sweep
        start_sweep();
        repeat (8) step();
        check("t6_pre_rst_vec", vec, 8);
        dc0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_vec", vec, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check_results("t6_rst", 0, 0, 0, 0, 0, 0);
        step();
        step();
        check("t6_no_done", done_cnt - dc0, 0);
        rst = 1'b0;
        start = 1'b1;
        step();
        check("t6_busy", busy, 1);
        check("t6_vec0", vec, 0);
        wait_done(0, cyc);
        check("t6_latency", cyc, 18);
        check_results("t6", 7, 13, 2, 9, 1, 0);
        start = 1'b0;
        step();
        step();
        check("t6_one_done", done_cnt - dc0, 1);
        check("t6_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
